// File: rtl/pwm_cfg_scheduler_if.sv
// pwm_cfg_scheduler_if
//   Host-side parameter-set handshake for pwm_cfg_scheduler.
//   master : host, drives cfg_valid and the requested parameter set
//   slave  : scheduler, drives cfg_ready
// Signals:
//   cfg_valid        host offers a parameter set
//   cfg_ready        scheduler can accept a set
//   cfg_period       requested period        (W bits)
//   cfg_init_carr    requested initial carrier (W bits)
//   cfg_compare      requested compare value (W bits)
//   cfg_clk_divider  requested divider       (5 bits)
//   cfg_dtime_A/B    requested dead times    (8 bits each)
//   upd_mode         0 immediate, 1 carrier zero, 2 carrier peak, 3 zero or peak
interface pwm_cfg_scheduler_if #(
   parameter int W = 16
);
   logic         cfg_valid;
   logic         cfg_ready;
   logic [W-1:0] cfg_period;
   logic [W-1:0] cfg_init_carr;
   logic [W-1:0] cfg_compare;
   logic [4:0]   cfg_clk_divider;
   logic [7:0]   cfg_dtime_A;
   logic [7:0]   cfg_dtime_B;
   logic [1:0]   upd_mode;

   modport master (
      output cfg_valid,
      output cfg_period,
      output cfg_init_carr,
      output cfg_compare,
      output cfg_clk_divider,
      output cfg_dtime_A,
      output cfg_dtime_B,
      output upd_mode,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_period,
      input  cfg_init_carr,
      input  cfg_compare,
      input  cfg_clk_divider,
      input  cfg_dtime_A,
      input  cfg_dtime_B,
      input  upd_mode,
      output cfg_ready
   );
endinterface

// File: rtl/pwm_cfg_scheduler.sv
// pwm_cfg_scheduler
//   Sits between the host register interface and pwm_16bits. Accepts a full
//   PWM parameter set over a valid/ready handshake, holds it in shadow
//   registers and commits it atomically to the live pwm_16bits inputs at the
//   selected carrier event. Also sequences the pwm_onoff run control.
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   cfg           parameter-set handshake (pwm_cfg_scheduler_if.slave)
//   run_req       host run/stop level
//   carrier       live carrier from pwm_16bits
//   pwm_clk       carrier step strobe from pwm_16bits
//   period, init_carr, compare, clk_divider, dtime_A, dtime_B
//                 live values to pwm_16bits
//   pwm_onoff     run control to pwm_16bits (1 = on)
//   commit_pulse  one-cycle strobe after each commit
//   cfg_err       sticky: a set with period 0 was rejected
// Build option:
//   PWM_CFG_SAFE_STOP_EN  when defined, a falling run_req only clears
//                         pwm_onoff at the next carrier-zero step.
module pwm_cfg_scheduler #(
   parameter int W = 16
) (
   input  logic                clk,
   input  logic                reset,
   pwm_cfg_scheduler_if.slave  cfg,
   input  logic                run_req,
   input  logic [W-1:0]        carrier,
   input  logic                pwm_clk,
   output logic [W-1:0]        period,
   output logic [W-1:0]        init_carr,
   output logic [W-1:0]        compare,
   output logic [4:0]          clk_divider,
   output logic [7:0]          dtime_A,
   output logic [7:0]          dtime_B,
   output logic                pwm_onoff,
   output logic                commit_pulse,
   output logic                cfg_err
);

   localparam logic [W-1:0] PERIOD_RST = W'(2000);

   typedef enum logic {
      IDLE,
      PENDING
   } state_t;

   state_t       state_q, state_d;
   logic         started_q;

   logic [W-1:0] sh_period;
   logic [W-1:0] sh_init_carr;
   logic [W-1:0] sh_compare;
   logic [4:0]   sh_clk_divider;
   logic [7:0]   sh_dtime_A;
   logic [7:0]   sh_dtime_B;
   logic [1:0]   sh_mode;

   logic         accept;
   logic         reject;
   logic         commit;
   logic         at_zero;
   logic         at_peak;
   logic         trigger;
   logic [W-1:0] compare_clamped;
   logic [W-1:0] init_clamped;

   // cfg_ready stays low until the first edge after reset release
   assign cfg.cfg_ready = started_q && (state_q == IDLE);

   assign at_zero = pwm_clk && (carrier == '0);
   assign at_peak = pwm_clk && (carrier == period);

   always_comb begin
      trigger = 1'b0;
      case (sh_mode)
         2'd0:    trigger = 1'b1;
         2'd1:    trigger = at_zero;
         2'd2:    trigger = at_peak;
         default: trigger = at_zero || at_peak;
      endcase
      // a stopped carrier never produces events, so commit right away
      if (!pwm_onoff)
         trigger = 1'b1;
   end

   assign compare_clamped = (sh_compare   > sh_period) ? sh_period : sh_compare;
   assign init_clamped    = (sh_init_carr > sh_period) ? sh_period : sh_init_carr;

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      reject  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cfg.cfg_valid && cfg.cfg_ready) begin
               if (cfg.cfg_period == '0) begin
                  reject = 1'b1;
               end else begin
                  accept  = 1'b1;
                  state_d = PENDING;
               end
            end
         end
         PENDING: begin
            if (trigger) begin
               commit  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         started_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sh_period      <= '0;
         sh_init_carr   <= '0;
         sh_compare     <= '0;
         sh_clk_divider <= '0;
         sh_dtime_A     <= '0;
         sh_dtime_B     <= '0;
         sh_mode        <= '0;
      end else if (accept) begin
         sh_period      <= cfg.cfg_period;
         sh_init_carr   <= cfg.cfg_init_carr;
         sh_compare     <= cfg.cfg_compare;
         sh_clk_divider <= cfg.cfg_clk_divider;
         sh_dtime_A     <= cfg.cfg_dtime_A;
         sh_dtime_B     <= cfg.cfg_dtime_B;
         sh_mode        <= cfg.upd_mode;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         period       <= PERIOD_RST;
         init_carr    <= '0;
         compare      <= '0;
         clk_divider  <= '0;
         dtime_A      <= '0;
         dtime_B      <= '0;
         commit_pulse <= 1'b0;
      end else begin
         commit_pulse <= commit;
         if (commit) begin
            period      <= sh_period;
            init_carr   <= init_clamped;
            compare     <= compare_clamped;
            clk_divider <= sh_clk_divider;
            dtime_A     <= sh_dtime_A;
            dtime_B     <= sh_dtime_B;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cfg_err <= 1'b0;
      else if (reject)
         cfg_err <= 1'b1;
      else if (accept)
         cfg_err <= 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pwm_onoff <= 1'b0;
      end else begin
`ifdef PWM_CFG_SAFE_STOP_EN
         // hold the carrier running until it wraps through zero; a renewed
         // run_req during the wait simply keeps it on
         if (run_req)
            pwm_onoff <= 1'b1;
         else if (at_zero)
            pwm_onoff <= 1'b0;
`else
         pwm_onoff <= run_req;
`endif
      end
   end

endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
module tb_pwm_cfg_scheduler;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic         run_req;
   logic [W-1:0] carrier;
   logic         pwm_clk;
   logic [W-1:0] period, init_carr, compare;
   logic [4:0]   clk_divider;
   logic [7:0]   dtime_A, dtime_B;
   logic         pwm_onoff, commit_pulse, cfg_err;

   int tests_run    = 0;
   int tests_failed = 0;

   pwm_cfg_scheduler_if #(.W(W)) cfg_bus ();

   pwm_cfg_scheduler #(.W(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .cfg          (cfg_bus.slave),
      .run_req      (run_req),
      .carrier      (carrier),
      .pwm_clk      (pwm_clk),
      .period       (period),
      .init_carr    (init_carr),
      .compare      (compare),
      .clk_divider  (clk_divider),
      .dtime_A      (dtime_A),
      .dtime_B      (dtime_B),
      .pwm_onoff    (pwm_onoff),
      .commit_pulse (commit_pulse),
      .cfg_err      (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drive one parameter set for exactly one accepting edge
   task automatic send_cfg(input logic [W-1:0] p, input logic [W-1:0] ic,
                           input logic [W-1:0] cmp, input logic [4:0] div,
                           input logic [7:0] da, input logic [7:0] db,
                           input logic [1:0] mode);
      cfg_bus.cfg_period      = p;
      cfg_bus.cfg_init_carr   = ic;
      cfg_bus.cfg_compare     = cmp;
      cfg_bus.cfg_clk_divider = div;
      cfg_bus.cfg_dtime_A     = da;
      cfg_bus.cfg_dtime_B     = db;
      cfg_bus.upd_mode        = mode;
      cfg_bus.cfg_valid       = 1'b1;
      tick();
      cfg_bus.cfg_valid       = 1'b0;
   endtask

   task automatic test_reset();
      reset   = 1'b0;
      run_req = 1'b0;
      carrier = '0;
      pwm_clk = 1'b0;
      cfg_bus.cfg_valid = 1'b0;
      repeat (2) tick();
      tests_run++; if (period !== 16'd2000) begin tests_failed++; $display("FAIL rst_period: got %0d expected 2000", period); end
      tests_run++; if (compare !== 16'd0) begin tests_failed++; $display("FAIL rst_compare: got %0d expected 0", compare); end
      tests_run++; if (init_carr !== 16'd0) begin tests_failed++; $display("FAIL rst_init_carr: got %0d expected 0", init_carr); end
      tests_run++; if ({clk_divider, dtime_A, dtime_B} !== 21'd0) begin tests_failed++; $display("FAIL rst_div_dt: got %0d expected 0", {clk_divider, dtime_A, dtime_B}); end
      tests_run++; if ({pwm_onoff, commit_pulse, cfg_err} !== 3'b000) begin tests_failed++; $display("FAIL rst_flags: got %b expected 000", {pwm_onoff, commit_pulse, cfg_err}); end
      tests_run++; if (cfg_bus.cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ready_in_reset: got %b expected 0", cfg_bus.cfg_ready); end
      reset = 1'b1;
      #1;
      tests_run++; if (cfg_bus.cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ready_at_release: got %b expected 0", cfg_bus.cfg_ready); end
      tick();
      tests_run++; if (cfg_bus.cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ready_after_edge: got %b expected 1", cfg_bus.cfg_ready); end
   endtask

   task automatic test_immediate();
      send_cfg(16'd1200, 16'd0, 16'd400, 5'd0, 8'd0, 8'd0, 2'd0);
      tests_run++; if (cfg_bus.cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL imm_ready_pending: got %b expected 0", cfg_bus.cfg_ready); end
      tests_run++; if (period !== 16'd2000) begin tests_failed++; $display("FAIL imm_period_before: got %0d expected 2000", period); end
      tick();
      tests_run++; if (period !== 16'd1200 || compare !== 16'd400) begin tests_failed++; $display("FAIL imm_commit: got %0d/%0d expected 1200/400", period, compare); end
      tests_run++; if (commit_pulse !== 1'b1) begin tests_failed++; $display("FAIL imm_pulse: got %b expected 1", commit_pulse); end
      tick();
      tests_run++; if (commit_pulse !== 1'b0) begin tests_failed++; $display("FAIL imm_pulse_end: got %b expected 0", commit_pulse); end
   endtask

   task automatic test_run_start();
      run_req = 1'b1;
      #1;
      tests_run++; if (pwm_onoff !== 1'b0) begin tests_failed++; $display("FAIL run_before_edge: got %b expected 0", pwm_onoff); end
      tick();
      tests_run++; if (pwm_onoff !== 1'b1) begin tests_failed++; $display("FAIL run_after_edge: got %b expected 1", pwm_onoff); end
   endtask

   task automatic test_mode1_zero();
      send_cfg(16'd1500, 16'd0, 16'd667, 5'd0, 8'd0, 8'd0, 2'd1);
      tests_run++; if (period !== 16'd1200) begin tests_failed++; $display("FAIL m1_hold0: got %0d expected 1200", period); end
      pwm_clk = 1'b1; carrier = 16'd5;
      tick();
      tests_run++; if (period !== 16'd1200) begin tests_failed++; $display("FAIL m1_hold_nonzero: got %0d expected 1200", period); end
      pwm_clk = 1'b0; carrier = 16'd0;
      tick();
      tests_run++; if (period !== 16'd1200) begin tests_failed++; $display("FAIL m1_hold_nostrobe: got %0d expected 1200", period); end
      pwm_clk = 1'b1; carrier = 16'd0;
      tick();
      tests_run++; if (period !== 16'd1500 || compare !== 16'd667) begin tests_failed++; $display("FAIL m1_commit: got %0d/%0d expected 1500/667", period, compare); end
      tests_run++; if (commit_pulse !== 1'b1 || cfg_bus.cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL m1_pulse_ready: got %b%b expected 11", commit_pulse, cfg_bus.cfg_ready); end
      pwm_clk = 1'b0; carrier = 16'd1;
      tick();
      tests_run++; if (commit_pulse !== 1'b0) begin tests_failed++; $display("FAIL m1_single_pulse: got %b expected 0", commit_pulse); end
   endtask

   task automatic test_back_to_back();
      send_cfg(16'd2000, 16'd0, 16'd500, 5'd0, 8'd0, 8'd0, 2'd0);
      tick();
      tests_run++; if (period !== 16'd2000) begin tests_failed++; $display("FAIL b2b_setup: got %0d expected 2000", period); end
      send_cfg(16'd1800, 16'd0, 16'd100, 5'd0, 8'd0, 8'd0, 2'd2);
      // second set offered and held while the first is pending
      cfg_bus.cfg_period = 16'd1600; cfg_bus.cfg_compare = 16'd50; cfg_bus.upd_mode = 2'd0;
      cfg_bus.cfg_valid = 1'b1;
      pwm_clk = 1'b1; carrier = 16'd0;
      tick();
      tests_run++; if (period !== 16'd2000 || cfg_bus.cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_no_zero_commit: got %0d/%b expected 2000/0", period, cfg_bus.cfg_ready); end
      carrier = 16'd1999;
      tick();
      tests_run++; if (period !== 16'd2000) begin tests_failed++; $display("FAIL b2b_hold_1999: got %0d expected 2000", period); end
      carrier = 16'd2000;
      tick();
      tests_run++; if (period !== 16'd1800 || compare !== 16'd100) begin tests_failed++; $display("FAIL b2b_peak_commit: got %0d/%0d expected 1800/100", period, compare); end
      tests_run++; if (cfg_bus.cfg_ready !== 1'b1 || commit_pulse !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_after: got %b%b expected 11", cfg_bus.cfg_ready, commit_pulse); end
      pwm_clk = 1'b0; carrier = 16'd10;
      tick();
      tests_run++; if (cfg_bus.cfg_ready !== 1'b0 || period !== 16'd1800) begin tests_failed++; $display("FAIL b2b_second_accept: got %b/%0d expected 0/1800", cfg_bus.cfg_ready, period); end
      cfg_bus.cfg_valid = 1'b0;
      tick();
      tests_run++; if (period !== 16'd1600 || compare !== 16'd50 || commit_pulse !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_commit: got %0d/%0d/%b expected 1600/50/1", period, compare, commit_pulse); end
   endtask

   task automatic test_clamp_and_err();
      send_cfg(16'd1500, 16'd2500, 16'd3000, 5'd7, 8'd11, 8'd22, 2'd0);
      tick();
      tests_run++; if (compare !== 16'd1500 || init_carr !== 16'd1500 || period !== 16'd1500) begin tests_failed++; $display("FAIL clamp_values: got %0d/%0d/%0d expected 1500/1500/1500", compare, init_carr, period); end
      tests_run++; if (clk_divider !== 5'd7 || dtime_A !== 8'd11 || dtime_B !== 8'd22) begin tests_failed++; $display("FAIL clamp_div_dt: got %0d/%0d/%0d expected 7/11/22", clk_divider, dtime_A, dtime_B); end
      send_cfg(16'd0, 16'd0, 16'd77, 5'd1, 8'd1, 8'd1, 2'd0);
      tests_run++; if (cfg_err !== 1'b1 || cfg_bus.cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL err_set: got %b%b expected 11", cfg_err, cfg_bus.cfg_ready); end
      tick();
      tests_run++; if (period !== 16'd1500 || compare !== 16'd1500 || commit_pulse !== 1'b0 || cfg_err !== 1'b1) begin tests_failed++; $display("FAIL err_live_kept: got %0d/%0d/%b/%b expected 1500/1500/0/1", period, compare, commit_pulse, cfg_err); end
      send_cfg(16'd1000, 16'd0, 16'd10, 5'd0, 8'd0, 8'd0, 2'd0);
      tests_run++; if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL err_clear: got %b expected 0", cfg_err); end
      tick();
      tests_run++; if (period !== 16'd1000) begin tests_failed++; $display("FAIL err_next_commit: got %0d expected 1000", period); end
   endtask

   task automatic test_stop();
      pwm_clk = 1'b1; carrier = 16'd700; run_req = 1'b0;
      tick();
`ifdef PWM_CFG_SAFE_STOP_EN
      tests_run++; if (pwm_onoff !== 1'b1) begin tests_failed++; $display("FAIL stop_hold_700: got %b expected 1", pwm_onoff); end
      carrier = 16'd300;
      tick();
      tests_run++; if (pwm_onoff !== 1'b1) begin tests_failed++; $display("FAIL stop_hold_300: got %b expected 1", pwm_onoff); end
      carrier = 16'd0;
      tick();
      tests_run++; if (pwm_onoff !== 1'b0) begin tests_failed++; $display("FAIL stop_at_zero: got %b expected 0", pwm_onoff); end
`else
      tests_run++; if (pwm_onoff !== 1'b0) begin tests_failed++; $display("FAIL stop_next_cycle: got %b expected 0", pwm_onoff); end
`endif
      pwm_clk = 1'b0; carrier = 16'd555;
      tick();
   endtask

   task automatic test_idle_commit();
      send_cfg(16'd900, 16'd0, 16'd300, 5'd0, 8'd0, 8'd0, 2'd1);
      tests_run++; if (cfg_bus.cfg_ready !== 1'b0 || period !== 16'd1000) begin tests_failed++; $display("FAIL idle_pending: got %b/%0d expected 0/1000", cfg_bus.cfg_ready, period); end
      tick();
      tests_run++; if (period !== 16'd900 || compare !== 16'd300 || commit_pulse !== 1'b1) begin tests_failed++; $display("FAIL idle_commit: got %0d/%0d/%b expected 900/300/1", period, compare, commit_pulse); end
   endtask

   task automatic test_reset_pending();
      run_req = 1'b1;
      tick();
      send_cfg(16'd444, 16'd0, 16'd44, 5'd3, 8'd3, 8'd3, 2'd1);
      carrier = 16'd10;
      tick();
      tests_run++; if (cfg_bus.cfg_ready !== 1'b0 || period !== 16'd900) begin tests_failed++; $display("FAIL rp_pending: got %b/%0d expected 0/900", cfg_bus.cfg_ready, period); end
      reset = 1'b0;
      #1;
      tests_run++; if (period !== 16'd2000 || compare !== 16'd0 || pwm_onoff !== 1'b0 || cfg_bus.cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL rp_async: got %0d/%0d/%b/%b expected 2000/0/0/0", period, compare, pwm_onoff, cfg_bus.cfg_ready); end
      run_req = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      tick();
      tests_run++; if (period !== 16'd2000 || clk_divider !== 5'd0 || commit_pulse !== 1'b0 || cfg_bus.cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL rp_discarded: got %0d/%0d/%b/%b expected 2000/0/0/1", period, clk_divider, commit_pulse, cfg_bus.cfg_ready); end
   endtask

   initial begin
      test_reset();
      test_immediate();
      test_run_start();
      test_mode1_zero();
      test_back_to_back();
      test_clamp_and_err();
      test_stop();
      test_idle_commit();
      test_reset_pending();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pwm_cfg_scheduler.md
# pwm_cfg_scheduler

Configuration scheduler sitting between the host register interface and `pwm_16bits`. Accepts a complete PWM parameter set via a valid/ready handshake, holds it in shadow registers, and commits it atomically to the live PWM inputs only at a selected carrier event, so the carrier never sees a torn or mid-period update. It also sequences the `pwm_onoff` run control.

## Interface
Parameters:
- `W`, 16, carrier/period/compare width (must match `pwm_16bits`)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `cfg_valid`  in  1  host offers a parameter set
- `cfg_ready`  out  1  scheduler can accept a set
- `cfg_period`, `cfg_init_carr`, `cfg_compare`  in  W each  requested values
- `cfg_clk_divider`  in  5  requested divider
- `cfg_dtime_A`, `cfg_dtime_B`  in  8 each  requested dead times
- `upd_mode`  in  2  0 immediate, 1 at carrier zero, 2 at carrier peak, 3 at zero or peak
- `run_req`  in  1  host run/stop level
- `carrier`  in  W  live carrier from `pwm_16bits`
- `pwm_clk`  in  1  carrier step strobe from `pwm_16bits`
- `period`, `init_carr`, `compare`  out  W each  live values to `pwm_16bits`
- `clk_divider`  out  5; `dtime_A`, `dtime_B`  out  8 each
- `pwm_onoff`  out  1  run control to `pwm_16bits` (1 = PWM_ON)
- `commit_pulse`  out  1  one-cycle strobe after each commit
- `cfg_err`  out  1  sticky: a set with period 0 was rejected; cleared by next accepted valid set

## Operation
- FSM states: IDLE, PENDING.
- IDLE: `cfg_ready`=1. On `cfg_valid && cfg_ready`: capture all `cfg_*` and `upd_mode` into shadow; go PENDING. If `cfg_period`==0: no capture, stay IDLE, set `cfg_err`.
- PENDING: `cfg_ready`=0. Commit when trigger true: mode 0 always; mode 1 `pwm_clk && carrier==0`; mode 2 `pwm_clk && carrier==period` (live period); mode 3 either. If `pwm_onoff`==0 the trigger is always true (carrier idle).
- Commit: shadow → all live outputs on the same edge; go IDLE; `commit_pulse`=1 for the following cycle.
- Clamping at commit: `compare` = min(shadow compare, shadow period); `init_carr` = min(shadow init_carr, shadow period). Unsigned W-bit compare.
- Zero and peak coincident (period such that both true): single commit.
- `cfg_valid` while PENDING is not accepted (held off by `cfg_ready`=0); host must keep it stable.
- Run control: `pwm_onoff` rises one cycle after `run_req` rises. Stop behaviour per Configuration.

## Timing
- Reset values: `period`=2000, `init_carr`=0, `compare`=0, `clk_divider`=0, `dtime_A`=`dtime_B`=0, `pwm_onoff`=0, `commit_pulse`=0, `cfg_err`=0, `cfg_ready`=0 while reset asserted, 1 from first edge after release; FSM IDLE, shadow cleared.
- Handshake edge N → PENDING from N. Mode 0: outputs update at edge N+1, `commit_pulse` high in cycle N+1..N+2.
- Event modes: trigger sampled in cycle M (M ≥ N+1) → outputs updated at edge ending cycle M; `cfg_ready` high the cycle after.
- Reset asserted mid-PENDING: shadow discarded, outputs to reset values immediately (asynchronous).

## Configuration
- `PWM_CFG_SAFE_STOP_EN` defined: `run_req` falling does not clear `pwm_onoff` until the next `pwm_clk && carrier==0`; rising `run_req` during the wait cancels the stop. Guarantees stop at period boundary.
- Undefined: `pwm_onoff` falls one cycle after `run_req` falls, regardless of carrier.

## Test plan
- Reset release: all outputs at reset values, `period`=2000; `cfg_ready`=1 one edge after release.
- PWM running, mode 1, send period 1500/compare 667: live values unchanged until `pwm_clk && carrier==0`, then update same edge; one `commit_pulse`.
- Mode 2 with period 2000: commit only at `carrier==2000` step; `cfg_valid` held during PENDING not accepted until after commit.
- Send compare 3000, init_carr 2500, period 1500: commits compare=1500, init_carr=1500; send period 0: `cfg_err`=1, live unchanged.
- `pwm_onoff`=0, mode 1: commit at edge N+1 without carrier event.
- Drop `run_req` at carrier 700 counting down: with `PWM_CFG_SAFE_STOP_EN` `pwm_onoff` falls at carrier 0; without, one cycle later.
